// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and controller state encodings,
// plus a helper that tells which opcodes write RESULT.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_ADDC = 4'd1,
      OP_SUB  = 4'd2,
      OP_SUBC = 4'd3,
      OP_CMP  = 4'd4,
      OP_AND  = 4'd5,
      OP_OR   = 4'd6,
      OP_EXOR = 4'd7,
      OP_TEST = 4'd8,
      OP_LSL  = 4'd9,
      OP_LSR  = 4'd10,
      OP_ROL  = 4'd11,
      OP_ROR  = 4'd12,
      OP_ASR  = 4'd13,
      OP_MOV  = 4'd14,
      OP_MUL  = 4'd15
   } alu_op_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } alu_state_t;

   // CMP and TEST only touch the flags; MUL writes RESULT through its own path.
   function automatic logic op_writes_result(input alu_op_t op);
      logic wr;
      case (op)
         OP_CMP, OP_TEST, OP_MUL: wr = 1'b0;
         default:                 wr = 1'b1;
      endcase
      return wr;
   endfunction

endpackage

// File: rtl/alu_mul.sv
// Shift-add unsigned multiplier: one add/shift step per clock for WIDTH steps.
// The product register holds the accumulator (upper half) and the multiplier shift register (lower half).
module alu_mul
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic                 step_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 last_o,
   output logic [2*WIDTH-1:0]   prod_next_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH:0]     addend_s;
   logic [WIDTH:0]     sum_s;

   assign last_o      = step_i && (cnt_q == CW'(WIDTH - 1));
   assign prod_next_o = prod_d;

   // Next-state for accumulator, multiplier shift register and step counter.
   always_comb begin
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      cnt_d    = cnt_q;
      addend_s = prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}};
      sum_s    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + addend_s;
      if (load_i) begin
         prod_d  = {{WIDTH{1'b0}}, b_i};
         mcand_d = a_i;
         cnt_d   = {CW{1'b0}};
      end else if (step_i) begin
         // The carry out of the add lands in the top bit as everything shifts right.
         prod_d = {sum_s, prod_q[WIDTH-1:1]};
         if (last_o) begin
            cnt_d = {CW{1'b0}};
         end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
         end
      end else begin
         prod_d  = prod_q;
         mcand_d = mcand_q;
         cnt_d   = cnt_q;
      end
   end

   // Multiplier datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q  <= {(2*WIDTH){1'b0}};
         mcand_q <= {WIDTH{1'b0}};
         cnt_q   <= {CW{1'b0}};
      end else begin
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops with C/Z flag registers
// and a multi-cycle shift-add MUL handled by alu_mul.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [3:0]       SEL,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             FLG_CLR,
   output logic [WIDTH-1:0] RESULT,
   output logic [WIDTH-1:0] HI,
   output logic             C,
   output logic             Z,
   output logic             BUSY,
   output logic             DONE
);

   alu_state_t         state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic               c_q, c_d;
   logic               z_q, z_d;
   logic               done_q, done_d;

   alu_op_t            op_s;
   logic [WIDTH:0]     alu_ext_s;
   logic               alu_z_s;
   logic               mul_load_s;
   logic               mul_step_s;
   logic               mul_last_s;
   logic [2*WIDTH-1:0] mul_prod_s;

   assign op_s       = alu_op_t'(SEL);
   assign mul_step_s = (state_q == ST_MUL);

   assign RESULT = result_q;
   assign HI     = hi_q;
   assign C      = c_q;
   assign Z      = z_q;
   assign BUSY   = (state_q == ST_MUL);
   assign DONE   = done_q;

   alu_mul #(.WIDTH(WIDTH)) u_mul (
      .clk         (CLK),
      .rst_n       (RST_N),
      .load_i      (mul_load_s),
      .step_i      (mul_step_s),
      .a_i         (A),
      .b_i         (B),
      .last_o      (mul_last_s),
      .prod_next_o (mul_prod_s)
   );

   // Single-cycle datapath: bit WIDTH of the extended result is the new carry/borrow.
   always_comb begin
      alu_ext_s = {1'b0, result_q};
      case (op_s)
         OP_ADD:         alu_ext_s = {1'b0, A} + {1'b0, B};
         OP_ADDC:        alu_ext_s = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, c_q};
         OP_SUB, OP_CMP: alu_ext_s = {1'b0, A} - {1'b0, B};
         OP_SUBC:        alu_ext_s = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, c_q};
         OP_AND, OP_TEST: alu_ext_s = {1'b0, A & B};
         OP_OR:          alu_ext_s = {1'b0, A | B};
         OP_EXOR:        alu_ext_s = {1'b0, A ^ B};
         OP_LSL:         alu_ext_s = {A, c_q};
         OP_LSR:         alu_ext_s = {A[0], c_q, A[WIDTH-1:1]};
         OP_ROL:         alu_ext_s = {A[WIDTH-1], A[WIDTH-2:0], A[WIDTH-1]};
         OP_ROR:         alu_ext_s = {A[0], A[0], A[WIDTH-1:1]};
         OP_ASR:         alu_ext_s = {A[0], A[WIDTH-1], A[WIDTH-1:1]};
         OP_MOV:         alu_ext_s = {1'b0, B};
         default:        alu_ext_s = {1'b0, result_q};
      endcase
      alu_z_s = (alu_ext_s[WIDTH-1:0] == {WIDTH{1'b0}});
   end

   // Controller: next state, register updates and DONE pulse.
   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      hi_d       = hi_q;
      c_d        = c_q;
      z_d        = z_q;
      done_d     = 1'b0;
      mul_load_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               if (op_s == OP_MUL) begin
                  mul_load_s = 1'b1;
                  state_d    = ST_MUL;
               end else begin
                  if (op_writes_result(op_s)) begin
                     result_d = alu_ext_s[WIDTH-1:0];
                  end else begin
                     result_d = result_q;
                  end
                  c_d    = alu_ext_s[WIDTH];
                  z_d    = alu_z_s;
                  done_d = 1'b1;
               end
            end else if (FLG_CLR) begin
               c_d = 1'b0;
               z_d = 1'b0;
            end else begin
               c_d = c_q;
               z_d = z_q;
            end
         end
         ST_MUL: begin
            if (mul_last_s) begin
               result_d = mul_prod_s[WIDTH-1:0];
               hi_d     = mul_prod_s[2*WIDTH-1:WIDTH];
               c_d      = (mul_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
               z_d      = (mul_prod_s == {(2*WIDTH){1'b0}});
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               state_d  = ST_MUL;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Architectural state registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         result_q <= {WIDTH{1'b0}};
         hi_q     <= {WIDTH{1'b0}};
         c_q      <= 1'b0;
         z_q      <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         c_q      <= c_d;
         z_q      <= z_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): a reference model pushes expected
// outputs to a scoreboard queue at issue time; they are popped when DONE is seen.
module tb_alu_seq;

   localparam int W = 8;
   localparam logic [3:0] ADD = 4'd0, ADDC = 4'd1, SUB = 4'd2, SUBC = 4'd3, CMP = 4'd4,
                          AND_ = 4'd5, OR_ = 4'd6, EXOR = 4'd7, TEST = 4'd8, LSL = 4'd9,
                          LSR = 4'd10, ROL = 4'd11, ROR = 4'd12, ASR = 4'd13, MOV = 4'd14,
                          MUL = 4'd15;

   logic         CLK, RST_N, START, FLG_CLR;
   logic [3:0]   SEL;
   logic [W-1:0] A, B, RESULT, HI;
   logic         C, Z, BUSY, DONE;

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         c;
      logic         z;
   } exp_t;

   exp_t         sb_q[$];
   exp_t         e;
   logic [W-1:0] m_res, m_hi;
   logic         m_c, m_z;
   int           checks = 0;
   int           errors = 0;

   alu_seq #(.WIDTH(W)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .SEL(SEL), .A(A), .B(B),
      .FLG_CLR(FLG_CLR), .RESULT(RESULT), .HI(HI), .C(C), .Z(Z), .BUSY(BUSY), .DONE(DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: updates model registers and pushes the expected outputs.
   task automatic model_push(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int ua, ub, ci, t;
      logic [31:0] tv;
      exp_t x;
      ua = int'(a); ub = int'(b); ci = int'(m_c);
      case (op)
         ADD:  begin t = ua + ub;      tv = t; m_res = tv[7:0]; m_c = (t > 255); end
         ADDC: begin t = ua + ub + ci; tv = t; m_res = tv[7:0]; m_c = (t > 255); end
         SUB:  begin t = ua - ub;      tv = t; m_res = tv[7:0]; m_c = (ua < ub); end
         SUBC: begin t = ua - ub - ci; tv = t; m_res = tv[7:0]; m_c = (ua < ub + ci); end
         AND_: begin m_res = a & b; m_c = 1'b0; end
         OR_:  begin m_res = a | b; m_c = 1'b0; end
         EXOR: begin m_res = a ^ b; m_c = 1'b0; end
         LSL:  begin m_c = a[7]; m_res = {a[6:0], ci[0]}; end
         LSR:  begin m_c = a[0]; m_res = {ci[0], a[7:1]}; end
         ROL:  begin m_c = a[7]; m_res = {a[6:0], a[7]}; end
         ROR:  begin m_c = a[0]; m_res = {a[0], a[7:1]}; end
         ASR:  begin m_c = a[0]; m_res = {a[7], a[7:1]}; end
         MOV:  begin m_res = b; m_c = 1'b0; end
         default: ;
      endcase
      if (op == CMP) begin
         t = ua - ub; tv = t;
         m_c = (ua < ub); m_z = (tv[7:0] == 8'h00);
      end else if (op == TEST) begin
         m_c = 1'b0; m_z = ((a & b) == 8'h00);
      end else if (op == MUL) begin
         t = ua * ub; tv = t;
         m_hi = tv[15:8]; m_res = tv[7:0]; m_c = (m_hi != 8'h00); m_z = (t == 0);
      end else begin
         m_z = (m_res == 8'h00);
      end
      x.res = m_res; x.hi = m_hi; x.c = m_c; x.z = m_z;
      sb_q.push_back(x);
   endtask

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      SEL = op; A = a; B = b; START = 1'b1;
      model_push(op, a, b);
   endtask

   task automatic test_reset();
      RST_N = 1'b0; START = 1'b0; FLG_CLR = 1'b0; SEL = 4'd0; A = 8'h00; B = 8'h00;
      m_res = 8'h00; m_hi = 8'h00; m_c = 1'b0; m_z = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      checks++; if (RESULT !== 8'h00) begin errors++; $display("FAIL reset_result got %h exp 00", RESULT); end
      checks++; if (HI !== 8'h00) begin errors++; $display("FAIL reset_hi got %h exp 00", HI); end
      checks++; if ({C, Z, BUSY, DONE} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {C, Z, BUSY, DONE}); end
      RST_N = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic test_add_chain();
      issue(ADD, 8'hFF, 8'h01);
      @(posedge CLK); #1; START = 1'b0;
      checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL add_done got %b exp 1", DONE); end
      e = sb_q.pop_front();
      checks++; if ({RESULT, HI, C, Z} !== e) begin errors++; $display("FAIL add_sb got %h exp %h", {RESULT, HI, C, Z}, e); end
      checks++; if ({RESULT, C, Z} !== {8'h00, 1'b1, 1'b1}) begin errors++; $display("FAIL add_spec got %h/%b%b exp 00/11", RESULT, C, Z); end
      @(posedge CLK); #1;
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b exp 0", DONE); end
      issue(ADDC, 8'h00, 8'h00);
      @(posedge CLK); #1; START = 1'b0;
      e = sb_q.pop_front();
      checks++; if ({DONE, RESULT, HI, C, Z} !== {1'b1, e}) begin errors++; $display("FAIL addc_sb got %h exp %h", {DONE, RESULT, HI, C, Z}, {1'b1, e}); end
      checks++; if ({RESULT, C, Z} !== {8'h01, 1'b0, 1'b0}) begin errors++; $display("FAIL addc_spec got %h/%b%b exp 01/00", RESULT, C, Z); end
   endtask

   task automatic test_sub_cmp();
      issue(SUB, 8'h10, 8'h20);
      @(posedge CLK); #1; START = 1'b0;
      e = sb_q.pop_front();
      checks++; if ({DONE, RESULT, HI, C, Z} !== {1'b1, e}) begin errors++; $display("FAIL sub_sb got %h exp %h", {DONE, RESULT, HI, C, Z}, {1'b1, e}); end
      checks++; if ({RESULT, C} !== {8'hF0, 1'b1}) begin errors++; $display("FAIL sub_spec got %h/%b exp F0/1", RESULT, C); end
      issue(CMP, 8'h42, 8'h42);
      @(posedge CLK); #1; START = 1'b0;
      e = sb_q.pop_front();
      checks++; if ({DONE, RESULT, HI, C, Z} !== {1'b1, e}) begin errors++; $display("FAIL cmp_sb got %h exp %h", {DONE, RESULT, HI, C, Z}, {1'b1, e}); end
      checks++; if ({RESULT, C, Z} !== {8'hF0, 1'b0, 1'b1}) begin errors++; $display("FAIL cmp_spec got %h/%b%b exp F0/01", RESULT, C, Z); end
   endtask

   task automatic test_mul();
      int  busy_n;
      bit  done_seen;
      issue(MUL, 8'hFF, 8'hFF);
      @(posedge CLK); #1; START = 1'b0;
      checks++; if ({BUSY, DONE} !== 2'b10) begin errors++; $display("FAIL mul_accept got %b exp 10", {BUSY, DONE}); end
      busy_n = 1; done_seen = 1'b0;
      for (int i = 0; i < 20 && !done_seen; i++) begin
         @(posedge CLK); #1;
         START = 1'b0;
         if (DONE === 1'b1) begin
            done_seen = 1'b1;
         end else if (BUSY === 1'b1) begin
            busy_n++;
            if (busy_n == 3) begin
               SEL = ADD; A = 8'h01; B = 8'h01; START = 1'b1;
            end
         end
      end
      START = 1'b0;
      checks++; if (!done_seen) begin errors++; $display("FAIL mul_timeout got no DONE exp DONE within 20 cycles"); end
      checks++; if (busy_n != 8) begin errors++; $display("FAIL mul_busy_cycles got %0d exp 8", busy_n); end
      e = sb_q.pop_front();
      checks++; if ({RESULT, HI, C, Z} !== e) begin errors++; $display("FAIL mul_sb got %h exp %h", {RESULT, HI, C, Z}, e); end
      checks++; if ({HI, RESULT, C, Z, BUSY} !== {8'hFE, 8'h01, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL mul_spec got %h%h/%b%b%b exp FE01/100", HI, RESULT, C, Z, BUSY); end
      @(posedge CLK); #1;
      checks++; if ({DONE, BUSY, RESULT} !== {2'b00, 8'h01}) begin errors++; $display("FAIL mul_after got %b/%h exp 00/01", {DONE, BUSY}, RESULT); end
   endtask

   task automatic test_reset_mid_mul();
      bit done_bad;
      issue(MUL, 8'h55, 8'h33);
      @(posedge CLK); #1; START = 1'b0;
      repeat (4) @(posedge CLK);
      #1; RST_N = 1'b0; #1;
      sb_q.delete();
      m_res = 8'h00; m_hi = 8'h00; m_c = 1'b0; m_z = 1'b0;
      checks++; if ({RESULT, HI, C, Z, BUSY, DONE} !== {16'h0000, 4'b0000}) begin errors++; $display("FAIL rst_mul_now got %h exp 00000", {RESULT, HI, C, Z, BUSY, DONE}); end
      done_bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         if (DONE !== 1'b0) done_bad = 1'b1;
      end
      RST_N = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1;
         if (DONE !== 1'b0 || BUSY !== 1'b0) done_bad = 1'b1;
      end
      checks++; if (done_bad) begin errors++; $display("FAIL rst_mul_nodone got DONE/BUSY high exp both low"); end
      issue(ADD, 8'h03, 8'h04);
      @(posedge CLK); #1; START = 1'b0;
      e = sb_q.pop_front();
      checks++; if ({DONE, RESULT, HI, C, Z} !== {1'b1, e}) begin errors++; $display("FAIL rst_add_sb got %h exp %h", {DONE, RESULT, HI, C, Z}, {1'b1, e}); end
      checks++; if (RESULT !== 8'h07) begin errors++; $display("FAIL rst_add_spec got %h exp 07", RESULT); end
   endtask

   task automatic test_flg_clr();
      issue(ADD, 8'hFF, 8'h02);
      @(posedge CLK); #1; START = 1'b0;
      e = sb_q.pop_front();
      checks++; if ({C, RESULT} !== {1'b1, 8'h01}) begin errors++; $display("FAIL flg_setup got %b/%h exp 1/01", C, RESULT); end
      FLG_CLR = 1'b1;
      @(posedge CLK); #1; FLG_CLR = 1'b0;
      m_c = 1'b0; m_z = 1'b0;
      checks++; if ({C, Z, DONE, RESULT} !== {3'b000, 8'h01}) begin errors++; $display("FAIL flg_clr_alone got %b/%h exp 000/01", {C, Z, DONE}, RESULT); end
      issue(ADD, 8'hFF, 8'h02);
      @(posedge CLK); #1; START = 1'b0;
      e = sb_q.pop_front();
      FLG_CLR = 1'b1;
      issue(ADD, 8'h80, 8'h80);
      @(posedge CLK); #1; START = 1'b0; FLG_CLR = 1'b0;
      e = sb_q.pop_front();
      checks++; if ({DONE, RESULT, HI, C, Z} !== {1'b1, e}) begin errors++; $display("FAIL flg_clr_start_sb got %h exp %h", {DONE, RESULT, HI, C, Z}, {1'b1, e}); end
      checks++; if ({C, Z, RESULT} !== {2'b11, 8'h00}) begin errors++; $display("FAIL flg_clr_start_spec got %b/%h exp 11/00", {C, Z}, RESULT); end
   endtask

   task automatic test_back_to_back();
      logic [3:0]   ops [18] = '{ADD, ADDC, SUB, SUBC, AND_, OR_, EXOR, TEST, LSL, LSL,
                                 LSR, LSR, ROL, ROR, ASR, MOV, CMP, MOV};
      logic [W-1:0] as  [18] = '{8'hF0, 8'h01, 8'h05, 8'h10, 8'hF0, 8'h0F, 8'hAA, 8'h0F, 8'h81, 8'h01,
                                 8'h03, 8'h02, 8'h81, 8'h01, 8'h81, 8'h77, 8'h01, 8'h00};
      logic [W-1:0] bs  [18] = '{8'h20, 8'h01, 8'h06, 8'h0F, 8'h3C, 8'h30, 8'hAA, 8'hF0, 8'h00, 8'h00,
                                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h5A};
      for (int i = 0; i < 18; i++) begin
         issue(ops[i], as[i], bs[i]);
         @(posedge CLK); #1;
         e = sb_q.pop_front();
         checks++;
         if ({DONE, RESULT, HI, C, Z} !== {1'b1, e}) begin
            errors++;
            $display("FAIL b2b_%0d op %0d got %h exp %h", i, ops[i], {DONE, RESULT, HI, C, Z}, {1'b1, e});
         end
      end
      START = 1'b0;
      @(posedge CLK); #1;
      checks++; if ({DONE, BUSY} !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b exp 00", {DONE, BUSY}); end
   endtask

   initial begin
      test_reset();
      test_add_chain();
      test_sub_cmp();
      test_mul();
      test_reset_mid_mul();
      test_flg_clr();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits (legal values 4..32).
REQ-002 Port: CLK  in  1  single system clock; all state changes on the rising edge.
REQ-003 Port: RST_N  in  1  asynchronous, active-low reset.
REQ-004 Port: START  in  1  request to execute one operation; sampled only when BUSY=0.
REQ-005 Port: SEL  in  4  opcode: 0 ADD, 1 ADDC, 2 SUB, 3 SUBC, 4 CMP, 5 AND, 6 OR, 7 EXOR, 8 TEST, 9 LSL, 10 LSR, 11 ROL, 12 ROR, 13 ASR, 14 MOV, 15 MUL.
REQ-006 Port: A  in  WIDTH  first operand.
REQ-007 Port: B  in  WIDTH  second operand.
REQ-008 Port: FLG_CLR  in  1  synchronous clear of the C and Z flag registers.
REQ-009 Port: RESULT  out  WIDTH  registered result; low half of the product for MUL.
REQ-010 Port: HI  out  WIDTH  registered high half of the MUL product.
REQ-011 Port: C  out  1  registered carry/borrow flag.
REQ-012 Port: Z  out  1  registered zero flag.
REQ-013 Port: BUSY  out  1  high while a MUL is in progress.
REQ-014 Port: DONE  out  1  one-cycle pulse when an operation's outputs become valid.

Function
REQ-015 States SHALL be IDLE and MUL; START=1 in IDLE is accepted at the rising edge; START while BUSY=1 is ignored and not queued.
REQ-016 Ops 0-14 SHALL complete at the accepting edge: RESULT/C/Z update there, DONE=1 for the following cycle, state stays IDLE.
REQ-017 MUL SHALL latch A and B at the accepting edge, enter MUL, and perform one shift-add step per cycle for WIDTH cycles; BUSY=1 throughout; at the WIDTH-th edge it writes RESULT/HI/C/Z, returns to IDLE, and DONE=1 for the following cycle.
REQ-018 START SHALL be accepted in the cycle DONE=1, giving back-to-back single-cycle ops at one per clock.
REQ-019 Arithmetic SHALL use a WIDTH+1-bit intermediate: C = bit WIDTH (carry for ADD/ADDC, borrow, i.e. A < B + cin, for SUB/SUBC/CMP); Z = 1 iff the low WIDTH bits are zero.
REQ-020 Carry-in for ADDC, SUBC, LSL and LSR SHALL be the current C flag register, enabling multi-word chaining.
REQ-021 Shifts: LSL {C,R}={A,Cf}; LSR {C,R}={A[0],Cf,A[W-1:1]}; ROL C=A[W-1], R={A[W-2:0],A[W-1]}; ROR C=A[0], R={A[0],A[W-1:1]}; ASR C=A[0], R={A[W-1],A[W-1:1]}.
REQ-022 Logic ops and MOV SHALL set C=0; MOV sets RESULT=B.
REQ-023 CMP and TEST SHALL update C and Z only; RESULT and HI hold their previous values.
REQ-024 MUL SHALL be unsigned W x W -> 2W; C = (HI != 0); Z = 1 iff the full 2W product is zero.
REQ-025 HI SHALL be written only by MUL and hold otherwise.
REQ-026 FLG_CLR in IDLE without START SHALL clear C and Z at the next edge; with START in the same cycle, the operation's flags win; FLG_CLR is ignored in MUL.

Reset
REQ-027 RST_N=0 SHALL immediately force RESULT=0, HI=0, C=0, Z=0, BUSY=0, DONE=0, state IDLE, and step counter 0.
REQ-028 Reset asserted during MUL SHALL abort the operation with no DONE pulse; the first START after release executes normally.

Structure
REQ-029 Package alu_pkg SHALL hold the 4-bit opcode enum alu_op_t and the state enum alu_state_t.
REQ-030 The shift-add multiplier datapath (accumulator, multiplier shift register, step counter) SHALL be the sub-module alu_mul.

Verification (WIDTH=8)
REQ-031 ADD A=0xFF B=0x01 -> RESULT=0x00, C=1, Z=1, DONE one cycle after the accepting edge.
REQ-032 Then ADDC A=0x00 B=0x00 -> RESULT=0x01, C=0, Z=0 (carry chained from the C flag).
REQ-033 SUB A=0x10 B=0x20 -> RESULT=0xF0, C=1; then CMP A=0x42 B=0x42 -> Z=1, C=0, RESULT remains 0xF0.
REQ-034 MUL A=0xFF B=0xFF -> BUSY=1 for 8 cycles, then HI=0xFE, RESULT=0x01, C=1, Z=0, one DONE pulse; an ADD START pulsed mid-MUL is ignored.
REQ-035 RST_N low at MUL step 4 -> all outputs 0 at once, no DONE; after release, ADD A=0x03 B=0x04 -> RESULT=0x07.
REQ-036 With C=1: FLG_CLR alone -> C=0, Z=0; FLG_CLR with ADD A=0x80 B=0x80 in the same cycle -> C=1, Z=1.
